rgb_to_luma: RTL and testbench
==============================

// Module: rgb_to_luma
// PURPOSE
//  Upstream neighbour of the 2D FIR stage: converts the 24-bit RGB pixel stream into the
//  8-bit luma stream (y/dv/hs/vs) the filter consumes.
//  Adds pixel column/row coordinates, aligned to the output stream.
//  Adds a frame-lock FSM so downstream never sees a partial first frame after reset or an error.
//  Fully pipelined: one pixel per clock, fixed latency, no back-pressure.
// PARAMETERS
//  MAX_COLS  1600  active pixels per line; col_o range 0..MAX_COLS-1
//  MAX_ROWS  900   active lines per frame; row_o range 0..MAX_ROWS-1
//  COEF_R    77    red weight, Q0.8
//  COEF_G    150   green weight, Q0.8
//  COEF_B    29    blue weight, Q0.8; COEF_R+COEF_G+COEF_B must equal 256
// PORTS
//  clk       in   1   pixel clock; one clock domain only
//  rst       in   1   asynchronous, active-low reset (0 = reset)
//  r_i       in   8   red component
//  g_i       in   8   green component
//  b_i       in   8   blue component
//  dv_i      in   1   active-pixel strobe
//  hs_i      in   1   horizontal sync, active high
//  vs_i      in   1   vertical sync, active high
//  y_o       out  8   luma; 0 whenever dv_o=0
//  dv_o      out  1   delayed dv_i, gated by lock
//  hs_o      out  1   delayed hs_i, never gated
//  vs_o      out  1   delayed vs_i, never gated
//  col_o     out  11  column index of the pixel on y_o
//  row_o     out  10  row index of the pixel on y_o
//  locked_o  out  1   1 = FSM in LOCK
//  err_o     out  1   sticky geometry error; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - all outputs and pipeline registers go to 0; FSM goes to SEEK
//   - sync-edge history registers go to 1, so a sync already high at release is not an edge
//  Latency: exactly 3 clocks from inputs to y_o/dv_o/hs_o/vs_o/col_o/row_o, all mutually aligned.
//  Datapath:
//   - S1: register the three 8x8 products, 16 bits each
//   - S2: register the sum, 17 bits
//   - S3: y = (sum + 128) >> 8, clamped to 255; y_o=0 if the S3 dv is 0
//  Edges: vs_rise = vs_i & ~vs_prev; hs_rise likewise; dv_fall = ~dv_i & dv_prev.
//  Counters (input side; delayed 3 clocks to col_o/row_o):
//   - col: cleared on hs_rise; +1 on each dv_i=1 cycle
//   - row: cleared on vs_rise; +1 on each dv_fall
//   - vs_rise has priority over dv_fall in the same cycle (row=0)
//   - hs_rise together with dv_i=1: col restarts at 0 for that pixel, then counts
//  FSM, 2 states:
//   - SEEK: dv_o forced 0; hs_o/vs_o still pass. vs_rise -> LOCK.
//   - LOCK: dv_o = delayed dv_i. Geometry error -> SEEK and err_o<=1.
//   - Geometry error: dv_i=1 with col=MAX_COLS, or dv_fall with row=MAX_ROWS.
//   - On the error cycle and after it, counters saturate (no wrap) until the next vs_rise.
//   - The gating decision is taken at input time and carried down the pipeline.
//     Effect: the first pixel after LOCK is entered is a row-0/col-0 pixel.
//     Effect: pixels already in flight when an error occurs still exit with their dv.
//  Reset mid-frame: remainder of that frame suppressed (dv_o=0) until the next vs_rise.
//  No input stall; inputs are sampled every clock.
// STRUCTURE
//  Package video_pkg:
//   - MAX_COLS, MAX_ROWS, COL_W=11, ROW_W=10
//   - BT.601 coefficient constants
//   - FSM state typedef {SEEK, LOCK}
//  Sub-module sync_delay #(WIDTH, DEPTH=3):
//   - async-reset shift register carrying {dv,hs,vs,col,row}
//   - reused by fir_filter for its own alignment
//  Top file holds: multiplier pipeline, edge detect, counters, FSM.
// TESTING
//  T1 reset release, then vs pulse, then line of R=G=B=200 -> y_o=200 three clocks after each pixel; col_o 0..N-1
//  T2 pixel R=255,G=0,B=0 -> y_o=77; pixel G=255 only -> y_o=149; pixel B=255 only -> y_o=29; all 255 -> y_o=255
//  T3 pixels before the first vs_rise after reset -> dv_o=0, locked_o=0; hs_o/vs_o follow input at latency 3
//  T4 1601 dv cycles in one line (MAX_COLS=1600) -> err_o=1, locked_o=0; dv_o=0 after the in-flight pixels drain
//  T5 rst pulled low mid-line -> all outputs 0 asynchronously; after release, dv_o stays 0 until the next vs_rise
//  T6 vs_rise and dv_fall in the same cycle -> row_o=0 for the next frame's first pixel; no err_o

Source files
------------

// File: rtl/video_pkg.sv
// Shared video constants, BT.601 luma weights, lock FSM states and the
// luma rounding/clamping helper.
package video_pkg;

    localparam int MAX_COLS = 1600;
    localparam int MAX_ROWS = 900;
    localparam int COL_W    = 11;
    localparam int ROW_W    = 10;

    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(MAX_COLS);
    localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(MAX_ROWS);

    // Q0.8 weights; they sum to 256 so full-scale white maps to 255.
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        LOCK = 1'b1
    } lock_state_t;

    function automatic logic [7:0] luma_round(input logic [16:0] sum);
        logic [17:0] rounded;
        rounded = {1'b0, sum} + 18'd128;
        if (rounded[17:8] > 10'd255) begin
            return 8'd255;
        end else begin
            return rounded[15:8];
        end
    endfunction

endpackage

// File: rtl/rgb_to_luma_if.sv
// Pixel-stream bundle: RGB input stream plus the luma/coordinate result stream.
interface rgb_to_luma_if;
    import video_pkg::*;

    logic [7:0]       r_i;
    logic [7:0]       g_i;
    logic [7:0]       b_i;
    logic             dv_i;
    logic             hs_i;
    logic             vs_i;
    logic [7:0]       y_o;
    logic             dv_o;
    logic             hs_o;
    logic             vs_o;
    logic [COL_W-1:0] col_o;
    logic [ROW_W-1:0] row_o;
    logic             locked_o;
    logic             err_o;

    modport master (
        output r_i, g_i, b_i, dv_i, hs_i, vs_i,
        input  y_o, dv_o, hs_o, vs_o, col_o, row_o, locked_o, err_o
    );

    modport slave (
        input  r_i, g_i, b_i, dv_i, hs_i, vs_i,
        output y_o, dv_o, hs_o, vs_o, col_o, row_o, locked_o, err_o
    );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth, asynchronously reset shift register used to keep sideband
// signals aligned with a pipelined datapath.
module sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift chain; every stage clears to zero on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= {WIDTH{1'b0}};
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/rgb_to_luma.sv
// RGB to 8-bit luma converter with pixel coordinates and a frame-lock FSM;
// three-clock fixed latency, one pixel per clock.
module rgb_to_luma
    import video_pkg::*;
(
    input logic          clk,
    input logic          rst,
    rgb_to_luma_if.slave bus
);

    localparam int SB_W = 3 + COL_W + ROW_W;

    logic             r_vs_prev;
    logic             r_hs_prev;
    logic             r_dv_prev;
    logic             w_vs_rise;
    logic             w_hs_rise;
    logic             w_dv_fall;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col;
    logic [COL_W-1:0] w_col_next;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row;
    logic [ROW_W-1:0] w_row_next;
    logic             w_geom_err;
    logic             w_dv_gated;
    lock_state_t      r_state;
    logic             r_err;

    logic [15:0]      r_prod_r;
    logic [15:0]      r_prod_g;
    logic [15:0]      r_prod_b;
    logic [16:0]      r_sum;

    logic [SB_W-1:0]  w_sb_in;
    logic [SB_W-1:0]  w_sb_out;
    logic             w_sb_dv;
    logic             w_sb_hs;
    logic             w_sb_vs;
    logic [COL_W-1:0] w_sb_col;
    logic [ROW_W-1:0] w_sb_row;

    logic [7:0]       r_y;
    logic             r_dv_o;
    logic             r_hs_o;
    logic             r_vs_o;
    logic [COL_W-1:0] r_col_o;
    logic [ROW_W-1:0] r_row_o;

    // Edge detection, effective coordinates of the current pixel, and the
    // saturating next-state of the counters.
    always_comb begin
        w_vs_rise  = bus.vs_i & ~r_vs_prev;
        w_hs_rise  = bus.hs_i & ~r_hs_prev;
        w_dv_fall  = ~bus.dv_i & r_dv_prev;
        w_col      = w_hs_rise ? {COL_W{1'b0}} : r_col;
        w_row      = w_vs_rise ? {ROW_W{1'b0}} : r_row;
        w_geom_err = (bus.dv_i & (w_col == COL_LIMIT)) |
                     (w_dv_fall & (w_row == ROW_LIMIT));
        if (bus.dv_i && (w_col != COL_LIMIT)) begin
            w_col_next = w_col + COL_W'(1'b1);
        end else begin
            w_col_next = w_col;
        end
        // A frame start wins over the end-of-line increment.
        if (w_dv_fall && !w_vs_rise && (w_row != ROW_LIMIT)) begin
            w_row_next = w_row + ROW_W'(1'b1);
        end else begin
            w_row_next = w_row;
        end
        w_dv_gated = bus.dv_i & (r_state == LOCK) & ~w_geom_err;
        w_sb_in    = {w_dv_gated, bus.hs_i, bus.vs_i, w_col, w_row};
    end

    // Sync history (held high in reset so a sync already asserted is not an edge) and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_prev <= 1'b1;
            r_hs_prev <= 1'b1;
            r_dv_prev <= 1'b0;
            r_col     <= {COL_W{1'b0}};
            r_row     <= {ROW_W{1'b0}};
        end else begin
            r_vs_prev <= bus.vs_i;
            r_hs_prev <= bus.hs_i;
            r_dv_prev <= bus.dv_i;
            r_col     <= w_col_next;
            r_row     <= w_row_next;
        end
    end

    // Frame-lock FSM with sticky geometry error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEEK;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                SEEK: begin
                    if (w_vs_rise) begin
                        r_state <= LOCK;
                    end
                end
                LOCK: begin
                    if (w_geom_err) begin
                        r_state <= SEEK;
                        r_err   <= 1'b1;
                    end
                end
                default: r_state <= SEEK;
            endcase
        end
    end

    // Stages 1 and 2: weighted products, then their sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prod_r <= 16'd0;
            r_prod_g <= 16'd0;
            r_prod_b <= 16'd0;
            r_sum    <= 17'd0;
        end else begin
            r_prod_r <= {8'd0, bus.r_i} * {8'd0, COEF_R};
            r_prod_g <= {8'd0, bus.g_i} * {8'd0, COEF_G};
            r_prod_b <= {8'd0, bus.b_i} * {8'd0, COEF_B};
            r_sum    <= {1'b0, r_prod_r} + {1'b0, r_prod_g} + {1'b0, r_prod_b};
        end
    end

    sync_delay #(
        .WIDTH (SB_W),
        .DEPTH (2)
    ) u_sideband (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_sb_in),
        .o_data (w_sb_out)
    );

    assign {w_sb_dv, w_sb_hs, w_sb_vs, w_sb_col, w_sb_row} = w_sb_out;

    // Stage 3: rounded luma, zeroed outside active pixels, and aligned sideband.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y     <= 8'd0;
            r_dv_o  <= 1'b0;
            r_hs_o  <= 1'b0;
            r_vs_o  <= 1'b0;
            r_col_o <= {COL_W{1'b0}};
            r_row_o <= {ROW_W{1'b0}};
        end else begin
            r_y     <= w_sb_dv ? luma_round(r_sum) : 8'd0;
            r_dv_o  <= w_sb_dv;
            r_hs_o  <= w_sb_hs;
            r_vs_o  <= w_sb_vs;
            r_col_o <= w_sb_col;
            r_row_o <= w_sb_row;
        end
    end

    assign bus.y_o      = r_y;
    assign bus.dv_o     = r_dv_o;
    assign bus.hs_o     = r_hs_o;
    assign bus.vs_o     = r_vs_o;
    assign bus.col_o    = r_col_o;
    assign bus.row_o    = r_row_o;
    assign bus.locked_o = (r_state == LOCK);
    assign bus.err_o    = r_err;

endmodule

// File: tb/tb_rgb_to_luma.sv
// Directed, table-driven bench for rgb_to_luma: luma values, latency,
// coordinates, frame lock, geometry error and asynchronous reset.
module tb_rgb_to_luma;

    logic clk;
    logic rst;

    rgb_to_luma_if bus ();

    rgb_to_luma u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        dv;
        logic        hs;
        logic        vs;
        logic [7:0]  y;
        logic        e_dv;
        logic [10:0] col;
        logic [9:0]  row;
    } vec_t;

    vec_t tv[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic dv, input logic hs, input logic vs);
        bus.r_i  = r;
        bus.g_i  = g;
        bus.b_i  = b;
        bus.dv_i = dv;
        bus.hs_i = hs;
        bus.vs_i = vs;
    endtask

    task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic dv, input logic hs, input logic vs,
                       input logic [7:0] y, input logic e_dv, input int col, input int row);
        vec_t v;
        v.r = r; v.g = g; v.b = b;
        v.dv = dv; v.hs = hs; v.vs = vs;
        v.y = y; v.e_dv = e_dv;
        v.col = 11'(col);
        v.row = 10'(row);
        tv.push_back(v);
    endtask

    // One table entry per clock; its outputs are expected three clocks later.
    task automatic run_tv(input string tag);
        vec_t v;
        int   n;
        n = tv.size();
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) drive(tv[c].r, tv[c].g, tv[c].b, tv[c].dv, tv[c].hs, tv[c].vs);
            else       drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            step();
            if (c >= 2) begin
                v = tv[c-2];
                check($sformatf("%s[%0d].y", tag, c-2),  int'(bus.y_o),  int'(v.y));
                check($sformatf("%s[%0d].dv", tag, c-2), int'(bus.dv_o), int'(v.e_dv));
                check($sformatf("%s[%0d].hs", tag, c-2), int'(bus.hs_o), int'(v.hs));
                check($sformatf("%s[%0d].vs", tag, c-2), int'(bus.vs_o), int'(v.vs));
                if (v.e_dv) begin
                    check($sformatf("%s[%0d].col", tag, c-2), int'(bus.col_o), int'(v.col));
                    check($sformatf("%s[%0d].row", tag, c-2), int'(bus.row_o), int'(v.row));
                end
            end
        end
        tv.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".y"},      int'(bus.y_o),      0);
        check({tag, ".dv"},     int'(bus.dv_o),     0);
        check({tag, ".hs"},     int'(bus.hs_o),     0);
        check({tag, ".vs"},     int'(bus.vs_o),     0);
        check({tag, ".col"},    int'(bus.col_o),    0);
        check({tag, ".row"},    int'(bus.row_o),    0);
        check({tag, ".locked"}, int'(bus.locked_o), 0);
        check({tag, ".err"},    int'(bus.err_o),    0);
    endtask

    initial begin
        rst = 1'b0;
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b1;

        // Before any frame start: no active output, syncs still pass.
        add(200, 200, 200, 0, 1, 0, 0, 0, 0, 0);
        add(200, 200, 200, 1, 0, 0, 0, 0, 0, 0);
        add(200, 200, 200, 1, 0, 0, 0, 0, 0, 0);
        add(200, 200, 200, 0, 1, 0, 0, 0, 0, 0);
        run_tv("t3");
        check("t3.locked", int'(bus.locked_o), 0);

        // Frame start, then a grey line.
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(200, 200, 200, 1, 0, 0, 200, 1, i, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_tv("t1");
        check("t1.locked", int'(bus.locked_o), 1);
        check("t1.err",    int'(bus.err_o),    0);

        // Primary colours and extremes on row 1.
        add(0,   0,   0,   0, 1, 0, 0,   0, 0, 1);
        add(255, 0,   0,   1, 0, 0, 77,  1, 0, 1);
        add(0,   255, 0,   1, 0, 0, 149, 1, 1, 1);
        add(0,   0,   255, 1, 0, 0, 29,  1, 2, 1);
        add(255, 255, 255, 1, 0, 0, 255, 1, 3, 1);
        add(0,   0,   0,   1, 0, 0, 0,   1, 4, 1);
        add(10,  20,  30,  1, 0, 0, 18,  1, 5, 1);
        add(0,   0,   0,   0, 0, 0, 0,   0, 0, 0);
        run_tv("t2");

        // Frame start coinciding with end of line resets the row.
        add(0,   0,   0,   0, 1, 0, 0,   0, 0, 0);
        add(100, 100, 100, 1, 0, 0, 100, 1, 0, 2);
        add(0,   0,   0,   0, 0, 1, 0,   0, 0, 0);
        add(0,   0,   0,   0, 1, 0, 0,   0, 0, 0);
        add(50,  50,  50,  1, 0, 0, 50,  1, 0, 0);
        add(0,   0,   0,   0, 0, 0, 0,   0, 0, 0);
        run_tv("t6");
        check("t6.err",    int'(bus.err_o),    0);
        check("t6.locked", int'(bus.locked_o), 1);

        // Over-long line: 1601 active pixels.
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 1600; i++) begin
            step();
            if (i == 2) begin
                check("t4.first_dv",  int'(bus.dv_o),  1);
                check("t4.first_col", int'(bus.col_o), 0);
            end
            if (i == 1000) check("t4.mid_col", int'(bus.col_o), 998);
        end
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("t4.last_dv",  int'(bus.dv_o),     1);
        check("t4.last_col", int'(bus.col_o),    1599);
        check("t4.last_y",   int'(bus.y_o),      128);
        check("t4.err",      int'(bus.err_o),    1);
        check("t4.locked",   int'(bus.locked_o), 0);
        step();
        check("t4.bad_dv", int'(bus.dv_o), 0);
        check("t4.bad_y",  int'(bus.y_o),  0);
        step();
        check("t4.drain_dv", int'(bus.dv_o), 0);

        // Relock, then reset in the middle of a line.
        add(0,  0,  0,  0, 0, 1, 0,  0, 0, 0);
        add(0,  0,  0,  0, 0, 0, 0,  0, 0, 0);
        add(0,  0,  0,  0, 1, 0, 0,  0, 0, 0);
        add(60, 60, 60, 1, 0, 0, 60, 1, 0, 0);
        add(60, 60, 60, 1, 0, 0, 60, 1, 1, 0);
        run_tv("t5a");
        check("t5a.err", int'(bus.err_o), 1);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(8'd60, 8'd60, 8'd60, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        check("t5.pre_y", int'(bus.y_o), 60);
        #2;
        rst = 1'b0;
        bus.vs_i = 1'b1;
        #1;
        check_all_zero("t5.async");
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        check("t5.vs_held_locked", int'(bus.locked_o), 0);
        check("t5.vs_held_dv",     int'(bus.dv_o),     0);
        bus.vs_i = 1'b0;
        repeat (3) step();
        check("t5.post_locked", int'(bus.locked_o), 0);
        check("t5.post_dv",     int'(bus.dv_o),     0);
        add(0,  0,  0,  0, 0, 1, 0,  0, 0, 0);
        add(0,  0,  0,  0, 0, 0, 0,  0, 0, 0);
        add(0,  0,  0,  0, 1, 0, 0,  0, 0, 0);
        add(90, 90, 90, 1, 0, 0, 90, 1, 0, 0);
        add(0,  0,  0,  0, 0, 0, 0,  0, 0, 0);
        run_tv("t5b");
        check("t5b.locked", int'(bus.locked_o), 1);
        check("t5b.err",    int'(bus.err_o),    0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
